// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit active-low 7-segment display.
// Snapshots data at frame wrap and blanks the start of every digit dwell.
module seg_scan_ctrl #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    output logic [2:0]  addr,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntLast = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    addr_q, addr_d;
    logic [31:0]   shadow_data_q, shadow_data_d;
    logic [7:0]    shadow_dp_q, shadow_dp_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_tick_q, frame_tick_d;
    logic          blank;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        frame_tick_d  = 1'b0;
        if (!en) begin
            cnt_d         = '0;
            shadow_data_d = data;
            shadow_dp_d   = dp;
        end else if (cnt_q == CntLast) begin
            cnt_d  = '0;
            addr_d = addr_q + 3'd1;
            if (addr_q == 3'd7) begin
                shadow_data_d = data;
                shadow_dp_d   = dp;
                frame_tick_d  = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Blanking compares against the next count so seg lines up with cnt in the same cycle.
    if (BLANK == 0) begin : g_noblank
        assign blank = 1'b0;
    end else begin : g_blank
        assign blank = (cnt_d < CW'(BLANK));
    end

    always_comb begin
        nibble = shadow_data_d[{addr_d, 2'b00} +: 4];
        seg_d  = 8'hFF;
        if (en && !blank) begin
            seg_d = {~shadow_dp_d[addr_d], hex7(nibble)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            addr_q        <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= 8'hFF;
            frame_tick_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign addr       = addr_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with blanking (BLANK=1) and
// one without (BLANK=0) share the same stimulus, DIV=4.
module tb_seg_scan_ctrl;

    typedef logic [7:0] code_t [8];

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [2:0]  addr, addr0;
    logic [7:0]  seg, seg0;
    logic        frame_tick, frame_tick0;

    int n_cmp = 0;
    int n_bad = 0;

    seg_scan_ctrl #(.DIV(4), .BLANK(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data       (data),
        .dp         (dp),
        .addr       (addr),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    seg_scan_ctrl #(.DIV(4), .BLANK(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data       (data),
        .dp         (dp),
        .addr       (addr0),
        .seg        (seg0),
        .frame_tick (frame_tick0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
        end
    endtask

    // Called at a negedge whose cycle is addr=0, cnt=0; returns at the next frame's first cycle.
    task automatic run_frame(input code_t codes, input bit tick0, input bit fresh,
                             input int chg_digit, input logic [31:0] chg_data,
                             input logic [7:0] chg_dp);
        logic [7:0] e1, e0;
        logic       et;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 4; c++) begin
                et = (d == 0 && c == 0) ? tick0 : 1'b0;
                e1 = (c == 0) ? 8'hFF : codes[d];
                e0 = (fresh && d == 0 && c == 0) ? 8'hFF : codes[d];
                check("addr", 32'(addr), 32'(d));
                check("addr_b0", 32'(addr0), 32'(d));
                check("tick", 32'(frame_tick), 32'(et));
                check("tick_b0", 32'(frame_tick0), 32'(et));
                check("seg", 32'(seg), 32'(e1));
                check("seg_b0", 32'(seg0), 32'(e0));
                if (d == chg_digit && c == 0) begin
                    data = chg_data;
                    dp   = chg_dp;
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        code_t ca, cb, cc, ce;
        ca = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        cb = '{8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E};
        cc = '{8'h00, 8'h80, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        ce = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

        rst_n = 1'b0;
        en    = 1'b0;
        data  = 32'h76543210;
        dp    = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("dis_seg", 32'(seg), 32'hFF);
        check("dis_addr", 32'(addr), 32'd0);
        en = 1'b1;

        run_frame(ca, 1'b0, 1'b1, 3, 32'hFFFFFFFF, 8'h00);
        run_frame(cb, 1'b1, 1'b0, 7, 32'h88888888, 8'h05);
        run_frame(cc, 1'b1, 1'b0, -1, 32'h0, 8'h0);

        // Advance to addr=5, cnt=2 of the next frame.
        for (int i = 0; i < 22; i++) @(negedge clk);
        check("pre_dis_addr", 32'(addr), 32'd5);
        check("pre_dis_seg", 32'(seg), 32'h80);
        check("pre_dis_seg_b0", 32'(seg0), 32'h80);
        en   = 1'b0;
        data = 32'h00A00000;
        dp   = 8'h20;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("dis_addr", 32'(addr), 32'd5);
            check("dis_seg", 32'(seg), 32'hFF);
            check("dis_seg_b0", 32'(seg0), 32'hFF);
            check("dis_tick", 32'(frame_tick), 32'd0);
        end
        en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("res_addr", 32'(addr), 32'd5);
            check("res_seg", 32'(seg), (c == 0) ? 32'hFF : 32'h08);
            check("res_seg_b0", 32'(seg0), (c == 0) ? 32'hFF : 32'h08);
            @(negedge clk);
        end
        check("res_next_addr", 32'(addr), 32'd6);
        check("res_next_seg", 32'(seg), 32'hFF);
        check("res_next_seg_b0", 32'(seg0), 32'hC0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_addr", 32'(addr), 32'd6);
        check("pre_rst_seg", 32'(seg), 32'hC0);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr", 32'(addr), 32'd0);
        check("arst_seg", 32'(seg), 32'hFF);
        check("arst_seg_b0", 32'(seg0), 32'hFF);
        check("arst_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(ce, 1'b0, 1'b1, -1, 32'h0, 8'h0);
        check("end_tick", 32'(frame_tick), 32'd1);
        check("end_addr", 32'(addr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
